// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem_responder memory model: width defaults,
// latency ceiling, FSM state encoding and an index-width helper.
package mem_pkg;

  localparam int MEM_AW_DEFAULT = 16;
  localparam int MEM_DW_DEFAULT = 32;
  localparam int LAT_MAX        = 8;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Array index width; a one-word array still needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// LAT-deep {vld, data} shift register. Data stages load only behind a valid bit, so the
// last stage holds the most recent response while no new one is arriving.
module mem_lat_pipe
  import mem_pkg::*;
#(
  parameter int LAT = 2,
  parameter int DW  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  localparam int STAGES = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

  logic [STAGES-1:0] vld;

  // Valid chain: cleared by reset so in-flight reads never respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld[0] <= in_vld;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          ld;
    logic [DW-1:0] src;
    logic [DW-1:0] q;

    if (g == 0) begin : g_first
      assign ld  = in_vld;
      assign src = in_data;
    end else begin : g_next
      assign ld  = vld[g-1];
      assign src = g_stage[g-1].q;
    end

    if (g == STAGES - 1) begin : g_out
      // Output stage is the visible mem_rdata register, so it alone resets to zero.
      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else if (ld) begin
          q <= src;
        end
      end
    end else begin : g_mid
      // Inner data stage, no reset needed: qualified by the valid chain.
      always_ff @(posedge clk) begin
        if (ld) begin
          q <= src;
        end
      end
    end
  end

  assign out_vld  = vld[STAGES-1];
  assign out_data = g_stage[STAGES-1].q;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder for the mem_req/mem_write interface.
// Define MEM_INIT_EN to fill array[i]=i after reset (mem_busy high meanwhile).
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_AW = MEM_AW_DEFAULT,
  parameter int MEM_DW = MEM_DW_DEFAULT,
  parameter int DEPTH  = 4096,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam int IW = idx_width(DEPTH);

  logic [MEM_DW-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;
  logic [IW-1:0]     mem_idx;
  logic              wr_en;
  logic [IW-1:0]     wr_idx;
  logic [MEM_DW-1:0] wr_data;
  logic [MEM_DW-1:0] rd_data;

  assign in_range = {1'b0, mem_addr} < (MEM_AW + 1)'(DEPTH);
  assign mem_idx  = mem_addr[IW-1:0];
  assign accept   = mem_req && !mem_busy && !rst;

`ifdef MEM_INIT_EN
  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] init_cnt;
  logic [IW-1:0] init_nx;
  logic          busy;

  // State, init counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      busy     <= 1'b1;
    end else begin
      state    <= state_nx;
      init_cnt <= init_nx;
      busy     <= (state_nx == ST_INIT);
    end
  end

  // Next state: one init write per cycle, leave INIT after word DEPTH-1.
  always_comb begin
    state_nx = state;
    init_nx  = init_cnt;
    case (state)
      ST_INIT: begin
        init_nx = init_cnt + IW'(1);
        if (init_cnt == IW'(DEPTH - 1)) begin
          state_nx = ST_SERVE;
        end else begin
          state_nx = ST_INIT;
        end
      end
      ST_SERVE: state_nx = ST_SERVE;
      default:  state_nx = ST_INIT;
    endcase
  end

  // Single write port: init sequence owns it until SERVE.
  always_comb begin
    if (state == ST_INIT) begin
      wr_en   = !rst;
      wr_idx  = init_cnt;
      wr_data = MEM_DW'(init_cnt);
    end else begin
      wr_en   = accept && mem_write && in_range;
      wr_idx  = mem_idx;
      wr_data = mem_wdata;
    end
  end

  assign mem_busy = busy;
`else
  assign mem_busy = 1'b0;
  assign wr_en    = accept && mem_write && in_range;
  assign wr_idx   = mem_idx;
  assign wr_data  = mem_wdata;
`endif

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Out-of-range reads return zero instead of aliasing into the array.
  always_comb begin
    if (in_range) begin
      rd_data = mem[mem_idx];
    end else begin
      rd_data = '0;
    end
  end

  // Error pulse in the cycle after an out-of-range accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= accept && !in_range;
    end
  end

  mem_lat_pipe #(
    .LAT (LAT),
    .DW  (MEM_DW)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (accept && !mem_write),
    .in_data  (rd_data),
    .out_vld  (mem_rdata_vld),
    .out_data (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LAT=2, DEPTH=4096); covers the
// MEM_INIT_EN build when that macro is defined.
module tb_mem_responder;

  localparam int LAT_TB   = 2;
  localparam int DEPTH_TB = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_rdata_vld;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  logic        mem_err;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          vld_cyc[$];
  logic [31:0] vld_dat[$];
  int          err_cyc[$];

  mem_responder #(
    .MEM_AW (16),
    .MEM_DW (32),
    .DEPTH  (DEPTH_TB),
    .LAT    (LAT_TB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata_vld (mem_rdata_vld),
    .mem_rdata     (mem_rdata),
    .mem_busy      (mem_busy),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rdata_vld) begin
      vld_cyc.push_back(cyc);
      vld_dat.push_back(mem_rdata);
    end
    if (mem_err) err_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    vld_cyc.delete();
    vld_dat.delete();
    err_cyc.delete();
  endtask

  // One request in the current cycle, then idle.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    mem_req   = 1'b1;
    mem_write = w;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_req   = 1'b0;
    mem_write = 1'b0;
  endtask

  // Bounded wait for the init sequence; returns cycles spent busy.
  task automatic wait_not_busy(output int n);
    n = 0;
    while (mem_busy && n < DEPTH_TB + 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic exp_busy;
`ifdef MEM_INIT_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (mem_rdata_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b want=0", mem_rdata_vld); end
    checks++; if (mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=00000000", mem_rdata); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", mem_err); end
    checks++; if (mem_busy !== exp_busy) begin failures++; $display("FAIL reset_busy got=%b want=%b", mem_busy, exp_busy); end
    rst = 1'b0;
`ifndef MEM_INIT_EN
    tick();
`endif
  endtask

`ifdef MEM_INIT_EN
  task automatic test_busy();
    int n;
    int t;
    clear_events();
    n = 0;
    repeat (100) begin tick(); n++; end
    issue(1'b1, 16'h0005, 32'hFFFF_FFFF); n++;
    issue(1'b0, 16'h0005, 32'h0); n++;
    issue(1'b0, 16'h1000, 32'h0); n++;
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL busy_mid got=%b want=1", mem_busy); end
    begin : wait_blk
      int m;
      wait_not_busy(m);
      n += m;
    end
    checks++; if (n != DEPTH_TB) begin failures++; $display("FAIL busy_cycles got=%0d want=%0d", n, DEPTH_TB); end
    checks++; if (vld_cyc.size() != 0) begin failures++; $display("FAIL busy_no_vld got=%0d want=0", vld_cyc.size()); end
    checks++; if (err_cyc.size() != 0) begin failures++; $display("FAIL busy_no_err got=%0d want=0", err_cyc.size()); end
    clear_events();
    t = cyc;
    issue(1'b0, 16'h0005, 32'h0);
    repeat (LAT_TB + 3) tick();
    checks++; if (vld_cyc.size() != 1 || vld_cyc[0] != t + LAT_TB) begin failures++; $display("FAIL busy_readback_vld got=%0d want=1", vld_cyc.size()); end
    else begin
      checks++; if (vld_dat[0] !== 32'h5) begin failures++; $display("FAIL busy_readback_data got=%h want=00000005", vld_dat[0]); end
    end
  endtask
`endif

  task automatic test_raw();
    int t;
    clear_events();
    t = cyc;
    issue(1'b1, 16'h0010, 32'hDEAD_BEEF);
    issue(1'b0, 16'h0010, 32'h0);
    repeat (6) tick();
    checks++; if (vld_cyc.size() != 1) begin failures++; $display("FAIL raw_count got=%0d want=1", vld_cyc.size()); end
    else begin
      checks++; if (vld_cyc[0] != t + 3) begin failures++; $display("FAIL raw_cycle got=%0d want=%0d", vld_cyc[0], t + 3); end
      checks++; if (vld_dat[0] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL raw_data got=%h want=deadbeef", vld_dat[0]); end
    end
    checks++; if (mem_rdata_vld !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL raw_hold got=%b/%h want=0/deadbeef", mem_rdata_vld, mem_rdata); end
    checks++; if (err_cyc.size() != 0) begin failures++; $display("FAIL raw_err got=%0d want=0", err_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    int t;
`ifndef MEM_INIT_EN
    for (int i = 0; i < 4; i++) issue(1'b1, 16'(i), 32'(i));
`endif
    clear_events();
    t = cyc;
    for (int i = 0; i < 4; i++) issue(1'b0, 16'(i), 32'h0);
    repeat (LAT_TB + 3) tick();
    checks++; if (vld_cyc.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", vld_cyc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (vld_cyc[i] != t + i + LAT_TB) begin failures++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", i, vld_cyc[i], t + i + LAT_TB); end
        checks++; if (vld_dat[i] !== 32'(i)) begin failures++; $display("FAIL b2b_data%0d got=%h want=%h", i, vld_dat[i], 32'(i)); end
      end
    end
  endtask

  task automatic test_out_of_range();
    int t;
    clear_events();
    t = cyc;
    issue(1'b1, 16'h0FFF, 32'hCAFE_0FFF);
    issue(1'b1, 16'h1000, 32'h1111_1111);
    issue(1'b0, 16'h1000, 32'h0);
    issue(1'b0, 16'h0FFF, 32'h0);
    repeat (LAT_TB + 3) tick();
    checks++; if (err_cyc.size() != 2) begin failures++; $display("FAIL oor_err_count got=%0d want=2", err_cyc.size()); end
    else begin
      checks++; if (err_cyc[0] != t + 2) begin failures++; $display("FAIL oor_err_wr_cycle got=%0d want=%0d", err_cyc[0], t + 2); end
      checks++; if (err_cyc[1] != t + 3) begin failures++; $display("FAIL oor_err_rd_cycle got=%0d want=%0d", err_cyc[1], t + 3); end
    end
    checks++; if (vld_cyc.size() != 2) begin failures++; $display("FAIL oor_vld_count got=%0d want=2", vld_cyc.size()); end
    else begin
      checks++; if (vld_cyc[0] != t + 2 + LAT_TB) begin failures++; $display("FAIL oor_vld_cycle got=%0d want=%0d", vld_cyc[0], t + 2 + LAT_TB); end
      checks++; if (vld_dat[0] !== 32'h0) begin failures++; $display("FAIL oor_rdata_zero got=%h want=00000000", vld_dat[0]); end
      checks++; if (vld_cyc[1] != t + 3 + LAT_TB) begin failures++; $display("FAIL oor_edge_cycle got=%0d want=%0d", vld_cyc[1], t + 3 + LAT_TB); end
      checks++; if (vld_dat[1] !== 32'hCAFE_0FFF) begin failures++; $display("FAIL oor_edge_data got=%h want=cafe0fff", vld_dat[1]); end
    end
  endtask

  task automatic test_reset_flush();
    int t;
    logic [31:0] exp;
    issue(1'b1, 16'h0030, 32'h5A5A_5A5A);
    clear_events();
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'h0030;
    tick();
    rst = 1'b1;
    mem_addr = 16'h0031;
    tick();
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (LAT_TB + 3) tick();
    checks++; if (vld_cyc.size() != 0) begin failures++; $display("FAIL flush_no_vld got=%0d want=0", vld_cyc.size()); end
`ifdef MEM_INIT_EN
    exp = 32'h30;
    begin : wait_blk
      int n;
      wait_not_busy(n);
    end
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL flush_init_timeout got=%b want=0", mem_busy); end
`else
    exp = 32'h5A5A_5A5A;
`endif
    clear_events();
    t = cyc;
    issue(1'b0, 16'h0030, 32'h0);
    repeat (LAT_TB + 3) tick();
    checks++; if (vld_cyc.size() != 1) begin failures++; $display("FAIL flush_readback_count got=%0d want=1", vld_cyc.size()); end
    else begin
      checks++; if (vld_cyc[0] != t + LAT_TB) begin failures++; $display("FAIL flush_readback_cycle got=%0d want=%0d", vld_cyc[0], t + LAT_TB); end
      checks++; if (vld_dat[0] !== exp) begin failures++; $display("FAIL flush_readback_data got=%h want=%h", vld_dat[0], exp); end
    end
  endtask

  initial begin
    #1;
    test_reset();
`ifdef MEM_INIT_EN
    test_busy();
`endif
    test_raw();
    test_back_to_back();
    test_out_of_range();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
